// File: rtl/cutting_pkg.sv
// Shared definitions for the cutting-driver command transmitter: request opcodes,
// Din bus command codes, index limit and the transmitter state encoding.
package cutting_pkg;

   typedef enum logic [2:0] {
      OP_SET_FREQ  = 3'd0,
      OP_RUN       = 3'd1,
      OP_STOP      = 3'd2,
      OP_SWEEP_ON  = 3'd3,
      OP_SWEEP_OFF = 3'd4,
      OP_DEFAULT   = 3'd5,
      OP_SCAN      = 3'd6,
      OP_RSVD      = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2,
      ST_DWELL = 2'd3
   } state_e;

   localparam logic [4:0] CODE_RUN       = 5'd21;
   localparam logic [4:0] CODE_STOP      = 5'd22;
   localparam logic [4:0] CODE_SWEEP_ON  = 5'd23;
   localparam logic [4:0] CODE_SWEEP_OFF = 5'd24;
   localparam logic [4:0] CODE_DEFAULT   = 5'd25;
   localparam logic [4:0] CODE_IDLE      = 5'd31;
   localparam logic [4:0] MAX_IDX        = 5'd20;

   // Frequency selection puts the index itself on the bus; SCAN picks its own step code.
   function automatic logic [4:0] op_code(input op_e op, input logic [4:0] arg);
      logic [4:0] code;
      case (op)
         OP_SET_FREQ:  code = arg;
         OP_RUN:       code = CODE_RUN;
         OP_STOP:      code = CODE_STOP;
         OP_SWEEP_ON:  code = CODE_SWEEP_ON;
         OP_SWEEP_OFF: code = CODE_SWEEP_OFF;
         OP_DEFAULT:   code = CODE_DEFAULT;
         default:      code = CODE_IDLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/cutting_cmd_tx_if.sv
// Request channel of the cutting command transmitter: valid/ready handshake with
// opcode, argument and the abort strobe.
interface cutting_cmd_tx_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [4:0] req_arg;
   logic       abort;

   modport master (output req_valid, req_op, req_arg, abort, input req_ready);
   modport slave  (input req_valid, req_op, req_arg, abort, output req_ready);
endinterface

// File: rtl/cutting_cmd_timer.sv
// Loadable 20-bit down-counter; expired is high while the count sits at zero.
// Shared by the hold, gap and dwell phases of the transmitter.
module cutting_cmd_timer (
   input  logic        clk40MHz,
   input  logic        rst,
   input  logic        load,
   input  logic [19:0] load_val,
   output logic        expired
);

   logic [19:0] count;

   always_ff @(posedge clk40MHz or posedge rst) begin
      if (rst) begin
         count <= 20'd0;
      end else if (load) begin
         count <= load_val;
      end else if (count != 20'd0) begin
         count <= count - 20'd1;
      end
   end

   assign expired = (count == 20'd0);

endmodule

// File: rtl/cutting_cmd_tx.sv
// Serialises driver commands onto the 5-bit Din bus: each code is held, followed by
// an idle-code gap. Optional SCAN stepping is enabled by defining CUTTING_CMD_SCAN_EN.
module cutting_cmd_tx
   import cutting_pkg::*;
#(
   parameter int HOLD_CYC  = 40,
   parameter int GAP_CYC   = 40,
   parameter int DWELL_CYC = 400000
) (
   input  logic             clk40MHz,
   input  logic             rst,
   cutting_cmd_tx_if.slave  req_bus,
   output logic [4:0]       Din_out,
   output logic [4:0]       cur_idx,
   output logic             done,
   output logic             err,
   output logic             aborted
);

   localparam logic [19:0] HOLD_LOAD = 20'(HOLD_CYC - 1);
   localparam logic [19:0] GAP_LOAD  = 20'(GAP_CYC - 1);

   state_e      state;
   op_e         op_in;
   logic        accept;
   logic        arg_bad;
   logic        illegal;
   logic        more_steps;
   logic        abort_seen;
   logic [4:0]  drive_code;
   logic        timer_load;
   logic [19:0] timer_val;
   logic        timer_expired;

   assign op_in             = op_e'(req_bus.req_op);
   assign req_bus.req_ready = (state == ST_IDLE);
   assign accept            = req_bus.req_valid && (state == ST_IDLE);
   assign arg_bad           = (req_bus.req_arg > MAX_IDX);

`ifdef CUTTING_CMD_SCAN_EN
   localparam logic [19:0] DWELL_LOAD = 20'(DWELL_CYC - 1);

   logic       scan_active;
   logic [4:0] scan_target;
   logic [4:0] scan_first;
   logic [4:0] scan_next;

   // Steps move one index at a time from the last driven index toward the target.
   always_comb begin
      scan_first = req_bus.req_arg;
      if (req_bus.req_arg > cur_idx) begin
         scan_first = cur_idx + 5'd1;
      end else if (req_bus.req_arg < cur_idx) begin
         scan_first = cur_idx - 5'd1;
      end
      scan_next = (scan_target > cur_idx) ? cur_idx + 5'd1 : cur_idx - 5'd1;
   end

   assign more_steps = scan_active && (cur_idx != scan_target);
`else
   logic [19:0] dwell_unused;
   assign dwell_unused = 20'(DWELL_CYC);
   assign more_steps   = 1'b0;
`endif

   always_comb begin
      case (op_in)
         OP_SET_FREQ: illegal = arg_bad;
`ifdef CUTTING_CMD_SCAN_EN
         OP_SCAN:     illegal = arg_bad;
`else
         OP_SCAN:     illegal = 1'b1;
`endif
         OP_RSVD:     illegal = 1'b1;
         default:     illegal = 1'b0;
      endcase
   end

   always_comb begin
      drive_code = op_code(op_in, req_bus.req_arg);
`ifdef CUTTING_CMD_SCAN_EN
      if (op_in == OP_SCAN) begin
         drive_code = scan_first;
      end
`endif
   end

   // The timer is reloaded on exactly the edges where the FSM changes phase.
   always_comb begin
      timer_load = 1'b0;
      timer_val  = GAP_LOAD;
      case (state)
         ST_IDLE: begin
            if (accept && !illegal) begin
               timer_load = 1'b1;
               timer_val  = HOLD_LOAD;
            end
         end
         ST_DRIVE: begin
            if (req_bus.abort) begin
               timer_load = 1'b1;
            end else if (timer_expired) begin
               timer_load = 1'b1;
`ifdef CUTTING_CMD_SCAN_EN
               if (more_steps) begin
                  timer_val = DWELL_LOAD;
               end
`endif
            end
         end
`ifdef CUTTING_CMD_SCAN_EN
         ST_DWELL: begin
            if (req_bus.abort) begin
               timer_load = 1'b1;
            end else if (timer_expired) begin
               timer_load = 1'b1;
               timer_val  = HOLD_LOAD;
            end
         end
`endif
         default: begin
         end
      endcase
   end

   cutting_cmd_timer u_timer (
      .clk40MHz (clk40MHz),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .expired  (timer_expired)
   );

   // Status pulses default low and are raised for a single cycle by the state that ends a request.
   always_ff @(posedge clk40MHz or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         Din_out     <= CODE_IDLE;
         cur_idx     <= 5'd0;
         done        <= 1'b0;
         err         <= 1'b0;
         aborted     <= 1'b0;
         abort_seen  <= 1'b0;
`ifdef CUTTING_CMD_SCAN_EN
         scan_active <= 1'b0;
         scan_target <= 5'd0;
`endif
      end else begin
         done    <= 1'b0;
         err     <= 1'b0;
         aborted <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     err <= 1'b1;
                  end else begin
                     state      <= ST_DRIVE;
                     Din_out    <= drive_code;
                     abort_seen <= 1'b0;
                     if (op_in == OP_SET_FREQ) begin
                        cur_idx <= drive_code;
                     end else if (op_in == OP_DEFAULT) begin
                        cur_idx <= 5'd0;
                     end
`ifdef CUTTING_CMD_SCAN_EN
                     scan_active <= (op_in == OP_SCAN);
                     scan_target <= req_bus.req_arg;
                     if (op_in == OP_SCAN) begin
                        cur_idx <= drive_code;
                     end
`endif
                  end
               end
            end
            ST_DRIVE: begin
               if (req_bus.abort) begin
                  state      <= ST_GAP;
                  Din_out    <= CODE_IDLE;
                  abort_seen <= 1'b1;
               end else if (timer_expired) begin
                  state   <= more_steps ? ST_DWELL : ST_GAP;
                  Din_out <= CODE_IDLE;
               end
            end
`ifdef CUTTING_CMD_SCAN_EN
            ST_DWELL: begin
               if (req_bus.abort) begin
                  state      <= ST_GAP;
                  abort_seen <= 1'b1;
               end else if (timer_expired) begin
                  state   <= ST_DRIVE;
                  Din_out <= scan_next;
                  cur_idx <= scan_next;
               end
            end
`endif
            ST_GAP: begin
               if (timer_expired) begin
                  state   <= ST_IDLE;
                  done    <= !abort_seen;
                  aborted <= abort_seen;
               end
            end
            default: begin
               state   <= ST_IDLE;
               Din_out <= CODE_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cutting_cmd_tx.sv
// Directed self-checking bench for cutting_cmd_tx; SCAN vectors run only when
// CUTTING_CMD_SCAN_EN is defined, otherwise SCAN is expected to be rejected.
module tb_cutting_cmd_tx;
   import cutting_pkg::*;

   logic       clk40MHz = 1'b0;
   logic       rst      = 1'b1;
   logic [4:0] Din_out;
   logic [4:0] cur_idx;
   logic       done;
   logic       err;
   logic       aborted;
   int         checks   = 0;
   int         errors   = 0;

   cutting_cmd_tx_if bus ();

   cutting_cmd_tx #(
      .HOLD_CYC  (40),
      .GAP_CYC   (40),
      .DWELL_CYC (100)
   ) dut (
      .clk40MHz (clk40MHz),
      .rst      (rst),
      .req_bus  (bus),
      .Din_out  (Din_out),
      .cur_idx  (cur_idx),
      .done     (done),
      .err      (err),
      .aborted  (aborted)
   );

   always #5 clk40MHz = ~clk40MHz;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Counts cycles showing the given bus code with all status pulses low; leaves time n cycles later.
   task automatic checkOutputSpan(input string tag, input logic [4:0] code, input int n);
      int good = 0;
      repeat (n) begin
         if (Din_out === code && done === 1'b0 && err === 1'b0 && aborted === 1'b0) good++;
         @(negedge clk40MHz);
      end
      checkOutput(tag, 32'(good), 32'(n));
   endtask

   task automatic applyStimulus(input op_e op, input logic [4:0] arg);
      checkOutput("ready_before_req", 32'(bus.req_ready), 32'd1);
      bus.req_op    = op;
      bus.req_arg   = arg;
      bus.req_valid = 1'b1;
      @(negedge clk40MHz);
      bus.req_valid = 1'b0;
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_arg   = 5'd0;
      bus.abort     = 1'b0;
      repeat (3) @(negedge clk40MHz);
      checkOutput("rst_din", 32'(Din_out), 32'd31);
      checkOutput("rst_idx", 32'(cur_idx), 32'd0);
      checkOutput("rst_pulses", 32'({done, err, aborted}), 32'd0);
      rst = 1'b0;
      @(negedge clk40MHz);
      checkOutput("ready_after_rst", 32'(bus.req_ready), 32'd1);

      $display("[TB] SET_FREQ 7");
      applyStimulus(OP_SET_FREQ, 5'd7);
      checkOutput("setf_idx", 32'(cur_idx), 32'd7);
      checkOutputSpan("setf_drive", 5'd7, 40);
      checkOutputSpan("setf_gap", 5'd31, 40);
      checkOutput("setf_done", 32'(done), 32'd1);
      checkOutput("setf_idx_end", 32'(cur_idx), 32'd7);
      @(negedge clk40MHz);
      checkOutput("setf_done_clear", 32'(done), 32'd0);

      $display("[TB] abort while idle");
      bus.abort = 1'b1;
      @(negedge clk40MHz);
      bus.abort = 1'b0;
      checkOutputSpan("idle_abort", 5'd31, 3);

      $display("[TB] STOP then RUN with valid held");
      bus.req_op    = OP_STOP;
      bus.req_arg   = 5'd0;
      bus.req_valid = 1'b1;
      @(negedge clk40MHz);
      checkOutput("busy_not_ready", 32'(bus.req_ready), 32'd0);
      bus.req_op = OP_RUN;
      checkOutputSpan("stop_drive", 5'd22, 40);
      checkOutputSpan("stop_gap", 5'd31, 40);
      checkOutput("stop_done", 32'(done), 32'd1);
      checkOutput("stop_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk40MHz);
      bus.req_valid = 1'b0;
      checkOutputSpan("run_drive", 5'd21, 40);
      checkOutputSpan("run_gap", 5'd31, 40);
      checkOutput("run_done", 32'(done), 32'd1);
      @(negedge clk40MHz);

      $display("[TB] illegal requests");
      applyStimulus(OP_SET_FREQ, 5'd21);
      checkOutput("bad_arg_err", 32'(err), 32'd1);
      checkOutput("bad_arg_din", 32'(Din_out), 32'd31);
      checkOutput("bad_arg_idx", 32'(cur_idx), 32'd7);
      @(negedge clk40MHz);
      checkOutput("bad_arg_err_clear", 32'(err), 32'd0);
      applyStimulus(OP_RSVD, 5'd0);
      checkOutput("rsvd_err", 32'(err), 32'd1);
      checkOutput("rsvd_idx", 32'(cur_idx), 32'd7);
      @(negedge clk40MHz);
      checkOutputSpan("rsvd_quiet", 5'd31, 10);

`ifdef CUTTING_CMD_SCAN_EN
      $display("[TB] SCAN 3 -> 1");
      applyStimulus(OP_SET_FREQ, 5'd3);
      checkOutputSpan("pre_scan_drive", 5'd3, 40);
      checkOutputSpan("pre_scan_gap", 5'd31, 40);
      checkOutput("pre_scan_done", 32'(done), 32'd1);
      @(negedge clk40MHz);
      applyStimulus(OP_SCAN, 5'd1);
      checkOutput("scan_idx_step1", 32'(cur_idx), 32'd2);
      checkOutputSpan("scan_drive2", 5'd2, 40);
      checkOutputSpan("scan_dwell", 5'd31, 100);
      checkOutput("scan_idx_step2", 32'(cur_idx), 32'd1);
      checkOutputSpan("scan_drive1", 5'd1, 40);
      checkOutputSpan("scan_gap", 5'd31, 40);
      checkOutput("scan_done", 32'(done), 32'd1);
      checkOutput("scan_idx_end", 32'(cur_idx), 32'd1);
      @(negedge clk40MHz);

      $display("[TB] SCAN to current index");
      applyStimulus(OP_SCAN, 5'd1);
      checkOutputSpan("scan_same_drive", 5'd1, 40);
      checkOutputSpan("scan_same_gap", 5'd31, 40);
      checkOutput("scan_same_done", 32'(done), 32'd1);
      @(negedge clk40MHz);

      $display("[TB] DEFAULT then SCAN 0 -> 20 with abort");
      applyStimulus(OP_DEFAULT, 5'd0);
      checkOutput("default_idx", 32'(cur_idx), 32'd0);
      checkOutputSpan("default_drive", 5'd25, 40);
      checkOutputSpan("default_gap", 5'd31, 40);
      checkOutput("default_done", 32'(done), 32'd1);
      @(negedge clk40MHz);
      applyStimulus(OP_SCAN, 5'd20);
      for (int s = 1; s <= 4; s++) begin
         checkOutputSpan("scan_up_drive", 5'(s), 40);
         checkOutputSpan("scan_up_dwell", 5'd31, 100);
      end
      checkOutputSpan("scan_up_drive5", 5'd5, 40);
      checkOutputSpan("scan_up_dwell5", 5'd31, 49);
      bus.abort = 1'b1;
      @(negedge clk40MHz);
      bus.abort = 1'b0;
      checkOutputSpan("abort_gap", 5'd31, 40);
      checkOutput("abort_pulse", 32'(aborted), 32'd1);
      checkOutput("abort_no_done", 32'(done), 32'd0);
      checkOutput("abort_idx", 32'(cur_idx), 32'd5);
      @(negedge clk40MHz);
      checkOutput("abort_pulse_clear", 32'(aborted), 32'd0);
`else
      $display("[TB] SCAN rejected without scan support");
      applyStimulus(OP_SCAN, 5'd3);
      checkOutput("scan_err", 32'(err), 32'd1);
      checkOutput("scan_err_din", 32'(Din_out), 32'd31);
      checkOutput("scan_err_idx", 32'(cur_idx), 32'd7);
      @(negedge clk40MHz);
`endif

      $display("[TB] reset during STOP drive");
      applyStimulus(OP_STOP, 5'd0);
      repeat (9) @(negedge clk40MHz);
      checkOutput("mid_drive_din", 32'(Din_out), 32'd22);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_din", 32'(Din_out), 32'd31);
      checkOutput("async_rst_idx", 32'(cur_idx), 32'd0);
      @(negedge clk40MHz);
      rst = 1'b0;
      @(negedge clk40MHz);
      checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);
      checkOutputSpan("post_rst_quiet", 5'd31, 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
